// File: rtl/ex_mul_unit_if.sv
// EX-stage multiplier handshake: operands and start/flush from the pipeline,
// stall/busy/valid/result back from the multiplier.
interface ex_mul_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] data1_i;
    logic [XLEN-1:0] data2_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, data1_i, data2_i, flush_i,
        input  stall_o, busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, op_i, data1_i, data2_i, flush_i,
        output stall_o, busy_o, valid_o, result_o
    );
endinterface

// File: rtl/ex_mul_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) on sign-magnitude operands.
// Radix-2 shift-add by default; define MUL_RADIX4_EN to retire two multiplier bits per cycle.
module ex_mul_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic          clk_i,
    input logic          rst_n_i,
    ex_mul_unit_if.slave bus_io
);

`ifdef MUL_RADIX4_EN
    localparam int unsigned NumIter = XLEN / 2;
    localparam int unsigned Shift   = 2;
`else
    localparam int unsigned NumIter = XLEN;
    localparam int unsigned Shift   = 1;
`endif
    localparam int unsigned CntW = $clog2(NumIter + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e              state_q, state_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                sign_q, sign_d;
    logic [1:0]          op_q, op_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
`ifdef MUL_RADIX4_EN
    logic [2*XLEN-1:0]   mcand3_q, mcand3_d;
`endif

    logic                sa, sb;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [2*XLEN-1:0]   addend, acc_sum, prod;
    logic                last;

    // Operand signs follow the op: rs1 signed for MULH/MULHSU, rs2 signed for MULH only.
    always_comb begin
        sa    = bus_io.data1_i[XLEN-1] & ((bus_io.op_i == 2'b01) | (bus_io.op_i == 2'b10));
        sb    = bus_io.data2_i[XLEN-1] & (bus_io.op_i == 2'b01);
        a_mag = sa ? (~bus_io.data1_i + XLEN'(1)) : bus_io.data1_i;
        b_mag = sb ? (~bus_io.data2_i + XLEN'(1)) : bus_io.data2_i;
    end

    always_comb begin
`ifdef MUL_RADIX4_EN
        case (mplier_q[1:0])
            2'b01:   addend = mcand_q;
            2'b10:   addend = mcand_q << 1;
            2'b11:   addend = mcand3_q;
            default: addend = '0;
        endcase
`else
        addend = mplier_q[0] ? mcand_q : '0;
`endif
        acc_sum = acc_q + addend;
        prod    = sign_q ? (~acc_sum + (2*XLEN)'(1)) : acc_sum;
        last    = (cnt_q == CntW'(1));
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        result_d = result_q;
        sign_d   = sign_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
`ifdef MUL_RADIX4_EN
        mcand3_d = mcand3_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus_io.start_i && !bus_io.flush_i) begin
                    state_d  = StCalc;
                    mcand_d  = {{XLEN{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    sign_d   = sa ^ sb;
                    op_d     = bus_io.op_i;
                    acc_d    = '0;
                    cnt_d    = CntW'(NumIter);
`ifdef MUL_RADIX4_EN
                    mcand3_d = {{XLEN{1'b0}}, a_mag} + {{(XLEN-1){1'b0}}, a_mag, 1'b0};
`endif
                end
            end
            StCalc: begin
                if (bus_io.flush_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << Shift;
                    mplier_d = mplier_q >> Shift;
                    cnt_d    = cnt_q - CntW'(1);
`ifdef MUL_RADIX4_EN
                    mcand3_d = mcand3_q << Shift;
`endif
                    if (last) begin
                        state_d  = StDone;
                        result_d = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d  = (state_d == StCalc);
        valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
            op_q     <= 2'b00;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifdef MUL_RADIX4_EN
            mcand3_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
`ifdef MUL_RADIX4_EN
            mcand3_q <= mcand3_d;
`endif
        end
    end

    // Reset gating keeps the hazard unit from seeing a stall while the unit is held in reset.
    assign bus_io.stall_o  = rst_n_i & (((state_q == StIdle) & bus_io.start_i & ~bus_io.flush_i)
                                        | (state_q == StCalc));
    assign bus_io.busy_o   = busy_q;
    assign bus_io.valid_o  = valid_q;
    assign bus_io.result_o = result_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit: directed RV32M vectors, random ops against a
// 64-bit arithmetic reference, held start, flush abort and asynchronous reset.
module tb_ex_mul_unit;

`ifdef MUL_RADIX4_EN
    localparam int N = 16;
`else
    localparam int N = 32;
`endif

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] last_exp = 32'h0;

    ex_mul_unit_if bus_if ();

    ex_mul_unit dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus_io  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
        xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Issues one multiply from IDLE (called at posedge+1) and returns with the unit back in IDLE.
    task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat, output logic stall_done);
        bus_if.start_i = 1'b1;
        bus_if.op_i    = op;
        bus_if.data1_i = a;
        bus_if.data2_i = b;
        #1;
        n_checks++;
        if (bus_if.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_stall: got %b want 1", bus_if.stall_o);
        end
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        bus_if.data1_i = $urandom;
        bus_if.data2_i = $urandom;
        n_checks++;
        if (bus_if.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_accept: got %b want 1", bus_if.busy_o);
        end
        lat = 0;
        while (bus_if.valid_o !== 1'b1 && lat < N + 8) begin
            @(posedge clk); #1;
            lat++;
        end
        res        = bus_if.result_o;
        stall_done = bus_if.stall_o;
        @(posedge clk); #1;
        n_checks++;
        if (bus_if.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_width: valid still %b one cycle after DONE", bus_if.valid_o);
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus_if.start_i = 1'b1;
        bus_if.flush_i = 1'b0;
        bus_if.op_i    = 2'b00;
        bus_if.data1_i = 32'h0;
        bus_if.data2_i = 32'h0;
        #12;
        n_checks++;
        if ({bus_if.stall_o, bus_if.busy_o, bus_if.valid_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: stall/busy/valid=%b want 000",
                     {bus_if.stall_o, bus_if.busy_o, bus_if.valid_o});
        end
        n_checks++;
        if (bus_if.result_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result: got %h want 00000000", bus_if.result_o);
        end
        bus_if.start_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        logic [31:0] t_a   [5] = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_b   [5] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'hFFFFFFFF};
        logic [31:0] t_exp [5] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                   32'h00000001};
        logic [31:0] res;
        int          lat;
        logic        sd;
        for (int i = 0; i < 5; i++) begin
            run_mul(t_op[i], t_a[i], t_b[i], res, lat, sd);
            n_checks++;
            if (res !== t_exp[i]) begin
                n_fail++;
                $display("FAIL directed_%0d result: got %h want %h", i, res, t_exp[i]);
            end
            n_checks++;
            if (lat != N) begin
                n_fail++;
                $display("FAIL directed_%0d latency: got %0d want %0d", i, lat, N);
            end
            n_checks++;
            if (sd !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_%0d stall_in_done: got %b want 0", i, sd);
            end
            n_checks++;
            if (bus_if.result_o !== t_exp[i]) begin
                n_fail++;
                $display("FAIL directed_%0d result_hold: got %h want %h", i, bus_if.result_o,
                         t_exp[i]);
            end
            last_exp = t_exp[i];
        end
    endtask

    task automatic test_random();
        logic [31:0] specials [4] = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h1};
        logic [1:0]  op;
        logic [31:0] a, b, res, exp;
        int          lat;
        logic        sd;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            exp = ref_mul(op, a, b);
            run_mul(op, a, b, res, lat, sd);
            n_checks++;
            if (res !== exp || lat != N) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                         i, op, a, b, res, lat, exp, N);
            end
            last_exp = exp;
        end
    endtask

    task automatic test_start_held();
        logic [31:0] a0, b0, a1, b1, res;
        int          nvalid;
        int          guard;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        bus_if.start_i = 1'b1;
        bus_if.op_i    = 2'b01;
        bus_if.data1_i = a0;
        bus_if.data2_i = b0;
        @(posedge clk); #1;
        nvalid = 0;
        res    = 32'h0;
        for (int i = 1; i <= N + 1; i++) begin
            if (i == 5) begin
                bus_if.data1_i = a1;
                bus_if.data2_i = b1;
            end
            @(posedge clk); #1;
            if (bus_if.valid_o === 1'b1) begin
                nvalid++;
                res = bus_if.result_o;
                n_checks++;
                if (bus_if.stall_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL held_stall_done: got %b want 0", bus_if.stall_o);
                end
            end
        end
        n_checks++;
        if (nvalid != 1) begin
            n_fail++;
            $display("FAIL held_valid_count: got %0d want 1", nvalid);
        end
        n_checks++;
        if (res !== ref_mul(2'b01, a0, b0)) begin
            n_fail++;
            $display("FAIL held_result: got %h want %h", res, ref_mul(2'b01, a0, b0));
        end
        n_checks++;
        if (bus_if.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL held_reaccept_stall: got %b want 1", bus_if.stall_o);
        end
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        n_checks++;
        if (bus_if.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL held_reaccept_busy: got %b want 1", bus_if.busy_o);
        end
        guard = 0;
        while (bus_if.valid_o !== 1'b1 && guard < N + 8) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (bus_if.result_o !== ref_mul(2'b01, a1, b1) || guard != N) begin
            n_fail++;
            $display("FAIL held_second: got %h lat %0d want %h lat %0d", bus_if.result_o,
                     guard, ref_mul(2'b01, a1, b1), N);
        end
        last_exp = ref_mul(2'b01, a1, b1);
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int nvalid;
        bus_if.start_i = 1'b1;
        bus_if.op_i    = 2'b00;
        bus_if.data1_i = $urandom | 32'h1;
        bus_if.data2_i = $urandom | 32'h3;
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus_if.flush_i = 1'b1;
        @(posedge clk); #1;
        bus_if.flush_i = 1'b0;
        n_checks++;
        if (bus_if.busy_o !== 1'b0 || bus_if.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: busy=%b stall=%b want 0 0", bus_if.busy_o, bus_if.stall_o);
        end
        nvalid = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk); #1;
            if (bus_if.valid_o === 1'b1) nvalid++;
        end
        n_checks++;
        if (nvalid != 0) begin
            n_fail++;
            $display("FAIL flush_no_valid: got %0d pulses want 0", nvalid);
        end
        n_checks++;
        if (bus_if.result_o !== last_exp) begin
            n_fail++;
            $display("FAIL flush_result_kept: got %h want %h", bus_if.result_o, last_exp);
        end
        bus_if.start_i = 1'b1;
        bus_if.flush_i = 1'b1;
        #1;
        n_checks++;
        if (bus_if.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_start_stall: got %b want 0", bus_if.stall_o);
        end
        @(posedge clk); #1;
        bus_if.start_i = 1'b0;
        bus_if.flush_i = 1'b0;
        n_checks++;
        if (bus_if.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_start_accepted: busy=%b want 0", bus_if.busy_o);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int          lat;
        logic        sd;
        bus_if.start_i = 1'b1;
        bus_if.op_i    = 2'b11;
        bus_if.data1_i = $urandom;
        bus_if.data2_i = $urandom;
        @(posedge clk); #1;
        bus_if.start_i = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_if.stall_o, bus_if.busy_o, bus_if.valid_o} !== 3'b000
            || bus_if.result_o !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: stall/busy/valid=%b result=%h want 000 00000000",
                     {bus_if.stall_o, bus_if.busy_o, bus_if.valid_o}, bus_if.result_o);
        end
        bus_if.start_i = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_mul(2'b00, 32'd3, 32'd5, res, lat, sd);
        n_checks++;
        if (res !== 32'd15 || lat != N) begin
            n_fail++;
            $display("FAIL post_reset_mul: got %h lat %0d want 0000000f lat %0d", res, lat, N);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
